// File: rtl/core_decoder_pkg.sv
// Shared encodings for the TinyGPU core decoder: opcodes, core states, mux selects
// and the decoded control bundle.
package core_decoder_pkg;

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_BRNZP = 4'b0001;
    localparam logic [3:0] OP_CMP   = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_MUL   = 4'b0101;
    localparam logic [3:0] OP_DIV   = 4'b0110;
    localparam logic [3:0] OP_LDR   = 4'b0111;
    localparam logic [3:0] OP_STR   = 4'b1000;
    localparam logic [3:0] OP_CONST = 4'b1001;
    localparam logic [3:0] OP_RET   = 4'b1111;

    localparam logic [2:0] STATE_IDLE    = 3'b000;
    localparam logic [2:0] STATE_FETCH   = 3'b001;
    localparam logic [2:0] STATE_DECODE  = 3'b010;
    localparam logic [2:0] STATE_REQUEST = 3'b011;
    localparam logic [2:0] STATE_WAIT    = 3'b100;
    localparam logic [2:0] STATE_EXECUTE = 3'b101;
    localparam logic [2:0] STATE_UPDATE  = 3'b110;
    localparam logic [2:0] STATE_DONE    = 3'b111;

    localparam logic [1:0] REG_IN_ARITH = 2'b00;
    localparam logic [1:0] REG_IN_MEM   = 2'b01;
    localparam logic [1:0] REG_IN_CONST = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_MUL = 2'b10;
    localparam logic [1:0] ALU_DIV = 2'b11;

    localparam logic ALU_OUT_ARITH = 1'b0;
    localparam logic ALU_OUT_CMP   = 1'b1;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       nzp_write;
        logic [1:0] reg_input_mux;
        logic [1:0] alu_arith_mux;
        logic       alu_output_mux;
        logic       pc_mux;
        logic       ret;
    } ctrl_t;

    // Opcodes 1010..1110 have no assigned instruction.
    function automatic logic is_reserved(input logic [3:0] op);
        return (op >= 4'b1010) && (op <= 4'b1110);
    endfunction

endpackage

// File: rtl/core_decoder_lut.sv
// Combinational opcode to control-bundle table; unassigned opcodes decode as NOP.
// Latency 0; no flow control.
module core_decoder_lut
    import core_decoder_pkg::*;
(
    input  logic [3:0] opcode,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_BRNZP: ctrl.pc_mux = 1'b1;
            OP_CMP: begin
                ctrl.alu_output_mux = ALU_OUT_CMP;
                ctrl.nzp_write      = 1'b1;
            end
            OP_ADD, OP_SUB, OP_MUL, OP_DIV: begin
                ctrl.reg_write     = 1'b1;
                ctrl.reg_input_mux = REG_IN_ARITH;
                ctrl.alu_arith_mux = opcode[1:0] - 2'b11;
            end
            OP_LDR: begin
                ctrl.reg_write     = 1'b1;
                ctrl.mem_read      = 1'b1;
                ctrl.reg_input_mux = REG_IN_MEM;
            end
            OP_STR: ctrl.mem_write = 1'b1;
            OP_CONST: begin
                ctrl.reg_write     = 1'b1;
                ctrl.reg_input_mux = REG_IN_CONST;
            end
            OP_RET: ctrl.ret = 1'b1;
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/core_decoder.sv
// TinyGPU per-core decoder: captures fields/control on DECODE, holds them until the next DECODE.
// Latency 1 cycle; enable low freezes all state; CORE_DECODER_ILLEGAL_OPCODE_EN adds a sticky illegal flag.
module core_decoder
    import core_decoder_pkg::*;
#(
    parameter int         INSTR_WIDTH = 16,
    parameter logic [2:0] DECODE      = STATE_DECODE,
    parameter logic [2:0] FETCH       = STATE_FETCH,
    parameter logic [2:0] IDLE        = STATE_IDLE
)
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [2:0]             core_state,
    input  logic [INSTR_WIDTH-1:0] instruction,
    output logic                   decoded_valid,
    output logic [3:0]             decoded_rd_address,
    output logic [3:0]             decoded_rs_address,
    output logic [3:0]             decoded_rt_address,
    output logic [2:0]             decoded_nzp,
    output logic [7:0]             decoded_immediate,
    output logic                   decoded_reg_write_enable,
    output logic                   decoded_mem_read_enable,
    output logic                   decoded_mem_write_enable,
    output logic                   decoded_nzp_write_enable,
    output logic [1:0]             decoded_reg_input_mux,
    output logic [1:0]             decoded_alu_arithmetic_mux,
    output logic                   decoded_alu_output_mux,
    output logic                   decoded_pc_mux,
    output logic                   decoded_ret,
    output logic                   illegal_opcode
);

    logic [3:0]  opcode;
    ctrl_t       lut_ctrl;
    ctrl_t       ctrl_q;
    logic [11:0] field_q;
    logic        valid_q;
    logic        capture;
    logic        invalidate;

    assign opcode     = instruction[INSTR_WIDTH-1 -: 4];
    assign capture    = enable && (core_state == DECODE);
    assign invalidate = enable && ((core_state == FETCH) || (core_state == IDLE));

    core_decoder_lut u_lut (
        .opcode (opcode),
        .ctrl   (lut_ctrl)
    );

    // All operand fields overlap instruction[11:0], so one register backs them all.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            field_q <= '0;
        end else if (capture) begin
            valid_q <= 1'b1;
            ctrl_q  <= lut_ctrl;
            field_q <= instruction[11:0];
        end else if (invalidate) begin
            valid_q <= 1'b0;
        end
    end

`ifdef CORE_DECODER_ILLEGAL_OPCODE_EN
    logic illegal_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else if (capture && is_reserved(opcode)) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal_opcode = illegal_q;
`else
    assign illegal_opcode = 1'b0;
`endif

    assign decoded_valid              = valid_q;
    assign decoded_rd_address         = field_q[11:8];
    assign decoded_rs_address         = field_q[7:4];
    assign decoded_rt_address         = field_q[3:0];
    assign decoded_nzp                = field_q[11:9];
    assign decoded_immediate          = field_q[7:0];
    assign decoded_reg_write_enable   = ctrl_q.reg_write;
    assign decoded_mem_read_enable    = ctrl_q.mem_read;
    assign decoded_mem_write_enable   = ctrl_q.mem_write;
    assign decoded_nzp_write_enable   = ctrl_q.nzp_write;
    assign decoded_reg_input_mux      = ctrl_q.reg_input_mux;
    assign decoded_alu_arithmetic_mux = ctrl_q.alu_arith_mux;
    assign decoded_alu_output_mux     = ctrl_q.alu_output_mux;
    assign decoded_pc_mux             = ctrl_q.pc_mux;
    assign decoded_ret                = ctrl_q.ret;

endmodule

// File: tb/tb_core_decoder.sv
// Scoreboard bench for core_decoder: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_core_decoder;

    typedef struct packed {
        logic        valid;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [3:0]  rt;
        logic [2:0]  nzp;
        logic [7:0]  imm;
        logic [10:0] ctrl;   // reg_wr, mem_rd, mem_wr, nzp_wr, rim[1:0], arith[1:0], aom, pc, ret
        logic        ill;
    } obs_t;

    // Hand-derived control vectors from the opcode table.
    localparam logic [10:0] C_NOP   = 11'b0000_00_00_000;
    localparam logic [10:0] C_BR    = 11'b0000_00_00_010;
    localparam logic [10:0] C_CMP   = 11'b0001_00_00_100;
    localparam logic [10:0] C_ADD   = 11'b1000_00_00_000;
    localparam logic [10:0] C_SUB   = 11'b1000_00_01_000;
    localparam logic [10:0] C_MUL   = 11'b1000_00_10_000;
    localparam logic [10:0] C_DIV   = 11'b1000_00_11_000;
    localparam logic [10:0] C_LDR   = 11'b1100_01_00_000;
    localparam logic [10:0] C_STR   = 11'b0010_00_00_000;
    localparam logic [10:0] C_CONST = 11'b1000_10_00_000;
    localparam logic [10:0] C_RET   = 11'b0000_00_00_001;

    localparam logic [2:0] S_IDLE = 3'b000, S_FETCH = 3'b001, S_DECODE = 3'b010,
                           S_REQ  = 3'b011, S_WAIT  = 3'b100, S_EXEC   = 3'b101, S_UPD = 3'b110;

`ifdef CORE_DECODER_ILLEGAL_OPCODE_EN
    localparam logic ILL_EN = 1'b1;
`else
    localparam logic ILL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [2:0]  core_state = S_IDLE;
    logic [15:0] instruction = 16'h0000;

    logic       decoded_valid;
    logic [3:0] decoded_rd_address, decoded_rs_address, decoded_rt_address;
    logic [2:0] decoded_nzp;
    logic [7:0] decoded_immediate;
    logic       decoded_reg_write_enable, decoded_mem_read_enable, decoded_mem_write_enable;
    logic       decoded_nzp_write_enable;
    logic [1:0] decoded_reg_input_mux, decoded_alu_arithmetic_mux;
    logic       decoded_alu_output_mux, decoded_pc_mux, decoded_ret, illegal_opcode;

    always #5 clk = ~clk;

    core_decoder dut (
        .clk                        (clk),
        .reset                      (reset),
        .enable                     (enable),
        .core_state                 (core_state),
        .instruction                (instruction),
        .decoded_valid              (decoded_valid),
        .decoded_rd_address         (decoded_rd_address),
        .decoded_rs_address         (decoded_rs_address),
        .decoded_rt_address         (decoded_rt_address),
        .decoded_nzp                (decoded_nzp),
        .decoded_immediate          (decoded_immediate),
        .decoded_reg_write_enable   (decoded_reg_write_enable),
        .decoded_mem_read_enable    (decoded_mem_read_enable),
        .decoded_mem_write_enable   (decoded_mem_write_enable),
        .decoded_nzp_write_enable   (decoded_nzp_write_enable),
        .decoded_reg_input_mux      (decoded_reg_input_mux),
        .decoded_alu_arithmetic_mux (decoded_alu_arithmetic_mux),
        .decoded_alu_output_mux     (decoded_alu_output_mux),
        .decoded_pc_mux             (decoded_pc_mux),
        .decoded_ret                (decoded_ret),
        .illegal_opcode             (illegal_opcode)
    );

    obs_t act;
    assign act = '{valid: decoded_valid, rd: decoded_rd_address, rs: decoded_rs_address,
                   rt: decoded_rt_address, nzp: decoded_nzp, imm: decoded_immediate,
                   ctrl: {decoded_reg_write_enable, decoded_mem_read_enable,
                          decoded_mem_write_enable, decoded_nzp_write_enable,
                          decoded_reg_input_mux, decoded_alu_arithmetic_mux,
                          decoded_alu_output_mux, decoded_pc_mux, decoded_ret},
                   ill: illegal_opcode};

    obs_t  exp_q[$];
    string name_q[$];
    obs_t  held = '0;
    int    total = 0;
    int    bad = 0;

    // Monitor: compares the registered outputs half a cycle after each captured expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t  e;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL %s: got=%h expected=%h", n, act, e);
            end
        end
    end

    // Drive one cycle and push what the outputs must be after that clock edge.
    task automatic step(input string n, input logic r, input logic en, input logic [2:0] st,
                        input logic [15:0] ins, input logic [10:0] ctrl, input logic rsv);
        reset       = r;
        enable      = en;
        core_state  = st;
        instruction = ins;
        if (r) begin
            held = '0;
        end else if (en && st == S_DECODE) begin
            held.valid = 1'b1;
            held.rd    = ins[11:8];
            held.rs    = ins[7:4];
            held.rt    = ins[3:0];
            held.nzp   = ins[11:9];
            held.imm   = ins[7:0];
            held.ctrl  = ctrl;
            held.ill   = held.ill | (ILL_EN & rsv);
        end else if (en && (st == S_FETCH || st == S_IDLE)) begin
            held.valid = 1'b0;
        end
        @(posedge clk);
        #1;
        exp_q.push_back(held);
        name_q.push_back(n);
    endtask

    initial begin
        step("reset0",      1, 0, S_IDLE,   16'h0000, C_NOP,   0);
        step("reset1",      1, 1, S_DECODE, 16'h3312, C_ADD,   0);
        step("add_cap",     0, 1, S_DECODE, 16'h3312, C_ADD,   0);
        step("add_req",     0, 1, S_REQ,    16'h5000, C_NOP,   0);
        step("cmp_cap",     0, 1, S_DECODE, 16'h2012, C_CMP,   0);
        step("cmp_exec",    0, 1, S_EXEC,   16'h5000, C_NOP,   0);
        step("cmp_wait",    0, 1, S_WAIT,   16'h5000, C_NOP,   0);
        step("cmp_upd",     0, 1, S_UPD,    16'h6FFF, C_NOP,   0);
        step("const_cap",   0, 1, S_DECODE, 16'h957F, C_CONST, 0);
        step("ldr_cap",     0, 1, S_DECODE, 16'h7120, C_LDR,   0);
        step("br_cap",      0, 1, S_DECODE, 16'h1A05, C_BR,    0);
        step("ret_cap",     0, 1, S_DECODE, 16'hF000, C_RET,   0);
        step("sub_cap",     0, 1, S_DECODE, 16'h4123, C_SUB,   0);
        step("mul_cap",     0, 1, S_DECODE, 16'h5456, C_MUL,   0);
        step("div_cap",     0, 1, S_DECODE, 16'h6789, C_DIV,   0);
        step("str_cap",     0, 1, S_DECODE, 16'h8ABC, C_STR,   0);
        step("nop_cap",     0, 1, S_DECODE, 16'h0FFF, C_NOP,   0);
        step("add_cap2",    0, 1, S_DECODE, 16'h3312, C_ADD,   0);
        step("dis_decode",  0, 0, S_DECODE, 16'h7120, C_LDR,   0);
        step("dis_fetch",   0, 0, S_FETCH,  16'h7120, C_NOP,   0);
        step("fetch_inval", 0, 1, S_FETCH,  16'h7120, C_NOP,   0);
        step("mul_cap2",    0, 1, S_DECODE, 16'h5ABC, C_MUL,   0);
        step("idle_inval",  0, 1, S_IDLE,   16'h0000, C_NOP,   0);
        step("ldr_cap2",    0, 1, S_DECODE, 16'h7DEF, C_LDR,   0);
        step("ldr_exec",    0, 1, S_EXEC,   16'h7DEF, C_NOP,   0);
        step("reset_exec",  1, 1, S_EXEC,   16'h7DEF, C_NOP,   0);
        step("illegal_a",   0, 1, S_DECODE, 16'hA000, C_NOP,   1);
        step("after_ill",   0, 1, S_DECODE, 16'h3312, C_ADD,   0);
        step("illegal_e",   0, 1, S_DECODE, 16'hE123, C_NOP,   1);
        step("ill_fetch",   0, 1, S_FETCH,  16'h0000, C_NOP,   0);
        step("ill_reset",   1, 0, S_IDLE,   16'h0000, C_NOP,   0);
        step("f_boundary",  0, 1, S_DECODE, 16'hF0F0, C_RET,   0);
        step("nine_bound",  0, 1, S_DECODE, 16'h9901, C_CONST, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/core_decoder.md
Name: core_decoder

Overview:
- Per-core instruction decoder for the TinyGPU compute core. It is the producer of the decoded control bundle that the ALU, LSU, register file, NZP/PC unit and scheduler consume.
- Captures the fetched 16-bit instruction during the DECODE core state and produces registered control fields.
- Holds those fields stable through REQUEST/WAIT/EXECUTE/UPDATE until the next DECODE.

Parameters:
- INSTR_WIDTH, 16, instruction word width; field positions below assume 16
- DECODE, 3'b010, core_state encoding on which capture occurs
- FETCH, 3'b001, core_state encoding that invalidates the held decode
- IDLE, 3'b000, core_state encoding that invalidates the held decode

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- enable  in  1  core active; when low, all registers hold
- core_state  in  3  scheduler state
- instruction  in  INSTR_WIDTH  fetched instruction, stable during DECODE
- decoded_valid  out  1  held decode corresponds to current instruction
- decoded_rd_address  out  4  instruction[11:8]
- decoded_rs_address  out  4  instruction[7:4]
- decoded_rt_address  out  4  instruction[3:0]
- decoded_nzp  out  3  instruction[11:9]
- decoded_immediate  out  8  instruction[7:0]
- decoded_reg_write_enable  out  1  register file write
- decoded_mem_read_enable  out  1  LSU load
- decoded_mem_write_enable  out  1  LSU store
- decoded_nzp_write_enable  out  1  NZP register update
- decoded_reg_input_mux  out  2  00 arithmetic, 01 memory, 10 constant
- decoded_alu_arithmetic_mux  out  2  00 ADD, 01 SUB, 10 MUL, 11 DIV
- decoded_alu_output_mux  out  1  0 arithmetic result, 1 comparison NZP
- decoded_pc_mux  out  1  1 = branch candidate
- decoded_ret  out  1  thread done
- illegal_opcode  out  1  sticky illegal flag (see Optional Feature)

Behaviour:
- Reset: every output is 0. Reset takes priority over all other conditions.
- Capture: when enable && core_state==DECODE, on posedge clk:
  - All control outputs are loaded from the opcode instruction[15:12].
  - Field outputs are always loaded from the raw bit slices, regardless of opcode.
  - decoded_valid is set to 1.
  - Latency: 1 cycle; values are visible the cycle after the DECODE edge.
- Opcode table (any control bit not listed is 0):
  - 0000 NOP: none
  - 0001 BRnzp: pc_mux=1
  - 0010 CMP: alu_output_mux=1, nzp_write_enable=1
  - 0011 ADD: reg_write=1, reg_input_mux=00, arith=00
  - 0100 SUB: reg_write=1, reg_input_mux=00, arith=01
  - 0101 MUL: reg_write=1, reg_input_mux=00, arith=10
  - 0110 DIV: reg_write=1, reg_input_mux=00, arith=11
  - 0111 LDR: reg_write=1, mem_read=1, reg_input_mux=01
  - 1000 STR: mem_write=1
  - 1001 CONST: reg_write=1, reg_input_mux=10
  - 1111 RET: ret=1
  - 1010-1110: decode as NOP (all control 0)
- Hold: in every other state, or when enable is low, all outputs keep their value, including when the instruction input changes.
- Invalidate: when enable && core_state is FETCH or IDLE, decoded_valid clears to 0. Control fields are left unchanged.
- DECODE in consecutive cycles re-captures on each cycle; the last capture wins.
- Reset asserted mid-instruction (any state): all outputs are 0 on the next cycle and decoded_valid is 0.

Optional Feature:
- Macro: CORE_DECODER_ILLEGAL_OPCODE_EN
- Defined:
  - Capturing opcode 1010-1110 sets illegal_opcode=1.
  - The flag is sticky and cleared only by reset.
  - The instruction still decodes as NOP.
- Undefined: illegal_opcode is tied to 0. The port remains present so the interface is unchanged.

Decomposition:
- Shared package holds:
  - opcode localparams (NOP…RET)
  - core_state encodings (IDLE..DONE, including EXECUTE=3'b101)
  - reg_input_mux encodings
  - alu_arithmetic_mux encodings
  - alu_output_mux encodings
- One natural sub-module is core_decoder_lut: combinational opcode → control bundle. The top level owns the capture/hold/valid registers and the sticky flag.

Test Plan:
1. ADD capture: instruction=0x3312 in DECODE → next cycle rd=3, rs=1, rt=2, reg_write=1, reg_input_mux=00, arith=00, alu_output_mux=0, valid=1.
2. CMP then hold: instruction=0x2012 in DECODE, then 0x5000 during EXECUTE → alu_output_mux=1, nzp_write=1, reg_write=0 remain unchanged through UPDATE.
3. CONST/LDR: 0x957F → immediate=0x7F, reg_input_mux=10, reg_write=1. 0x7120 → mem_read=1, reg_input_mux=01, mem_write=0.
4. Branch/RET: 0x1A05 → nzp=3'b101, immediate=0x05, pc_mux=1, reg_write=0. Then 0xF000 → ret=1, pc_mux=0.
5. Enable/invalidate: DECODE with enable=0 → no change. FETCH with enable=1 → valid=0, other fields retained. Reset during EXECUTE → all outputs 0.
6. Illegal opcode: 0xA000 in DECODE → all control 0. With macro defined: illegal_opcode=1 and stays 1 after a following ADD, until reset. Without macro: illegal_opcode=0.
